max6675_scan_ctrl: RTL and testbench

//  Parametrised multi-channel MAX6675 thermocouple reader; successor to the single-chip temperature front end.

---
 rtl/max6675_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_max6675_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max6675_scan_ctrl.sv
// rtl/max6675_scan_ctrl.sv - periodic multi-chip MAX6675 thermocouple scanner on a shared SPI bus
//
// Purpose: every SAMPLE_PERIOD clocks (when enabled), read one 16-bit frame from each of NUM_CH
// MAX6675 chips in turn and present the decoded reading with a one-cycle sample_valid strobe.
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   enable            allow periodic scans to start
//   spi_cs_n          per-chip chip selects (at most one low)
//   spi_sclk          serial clock, idle low
//   spi_miso          shared SO line, already synchronised
//   sample_valid      one-cycle strobe; sample_* change only with it
//   sample_ch         channel of the current sample
//   sample_raw        frame[14:3], 0.25 C per LSB
//   sample_celsius    frame[14:5], whole degrees C
//   sample_open       frame[2], thermocouple open
//   sample_fault      frame[15] | frame[1]
//   busy              a scan is in progress
module max6675_scan_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int SCLK_DIV      = 8,
    parameter int CS_SETUP      = 8,
    parameter int SAMPLE_PERIOD = 12_500_000,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [NUM_CH-1:0] spi_cs_n,
    output logic              spi_sclk,
    input  logic              spi_miso,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [11:0]       sample_raw,
    output logic [9:0]        sample_celsius,
    output logic              sample_open,
    output logic              sample_fault,
    output logic              busy
);

    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int T_MAX = (CS_SETUP > SCLK_DIV) ? CS_SETUP : SCLK_DIV;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PER_W-1:0]   r_period;
    logic [TW-1:0]      r_timer;
    logic [4:0]         r_bit;
    logic [CH_W-1:0]    r_ch;
    logic [15:0]        r_shift;
    logic [NUM_CH-1:0]  r_cs_n;
    logic               r_sclk;
    logic               r_valid;
    logic [CH_W-1:0]    r_sample_ch;
    logic [11:0]        r_raw;
    logic [9:0]         r_celsius;
    logic               r_open;
    logic               r_fault;
    logic               r_busy;

    logic               w_tick;
    logic               w_last_ch;
    logic [CH_W-1:0]    w_next_ch;

    assign w_tick    = (r_period == PER_W'(SAMPLE_PERIOD - 1));
    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
    assign w_next_ch = r_ch + 1'b1;

    // Chip-select pattern with only the addressed chip pulled low.
    function automatic logic [NUM_CH-1:0] cs_for(input logic [CH_W-1:0] ch);
        cs_for = ~(NUM_CH'(1) << ch);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_period    <= '0;
            r_timer     <= '0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_shift     <= '0;
            r_cs_n      <= '1;
            r_sclk      <= 1'b0;
            r_valid     <= 1'b0;
            r_sample_ch <= '0;
            r_raw       <= '0;
            r_celsius   <= '0;
            r_open      <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_period <= w_tick ? '0 : r_period + 1'b1;

            case (r_state)
                S_IDLE: begin
                    // A tick arriving while a scan runs is simply lost.
                    if (w_tick && enable) begin
                        r_state <= S_SETUP;
                        r_ch    <= '0;
                        r_cs_n  <= cs_for('0);
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SETUP: begin
                    // The setup window doubles as the low phase before the first
                    // rise, so the first rise lands CS_SETUP clocks after CS_n falls.
                    if (r_timer == TW'(CS_SETUP - 1)) begin
                        r_state <= S_SHIFT;
                        r_sclk  <= 1'b1;
                        r_shift <= {r_shift[14:0], spi_miso};
                        r_bit   <= 5'd1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_SHIFT: begin
                    // SO changes on the chip's falling edge, so it is stable when
                    // captured on the clock edge that raises sclk.
                    if (r_timer == TW'(SCLK_DIV - 1)) begin
                        r_timer <= '0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                        end else if (r_bit == 5'd16) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[14:0], spi_miso};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_timer == TW'(SCLK_DIV - 1)) begin
                        r_state <= S_DONE;
                        r_cs_n  <= '1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DONE: begin
                    if (r_timer == '0) begin
                        r_valid     <= 1'b1;
                        r_sample_ch <= r_ch;
                        r_raw       <= r_shift[14:3];
                        r_celsius   <= r_shift[14:5];
                        r_open      <= r_shift[2];
                        r_fault     <= r_shift[15] | r_shift[1];
                    end
                    // Staying here SCLK_DIV cycles sets the CS_n-high gap between chips.
                    if (r_timer == TW'(SCLK_DIV - 1)) begin
                        r_timer <= '0;
                        if (w_last_ch) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_SETUP;
                            r_ch    <= w_next_ch;
                            r_cs_n  <= cs_for(w_next_ch);
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= '1;
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_cs_n       = r_cs_n;
    assign spi_sclk       = r_sclk;
    assign sample_valid   = r_valid;
    assign sample_ch      = r_sample_ch;
    assign sample_raw     = r_raw;
    assign sample_celsius = r_celsius;
    assign sample_open    = r_open;
    assign sample_fault   = r_fault;
    assign busy           = r_busy;

endmodule

// File: tb/tb_max6675_scan_ctrl.sv
// tb/tb_max6675_scan_ctrl.sv - scoreboard bench for max6675_scan_ctrl
module tb_max6675_scan_ctrl;

    localparam int NUM_CH   = 3;
    localparam int SCLK_DIV = 4;
    localparam int CS_SETUP = 8;
    localparam int P        = 600;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              spi_miso = 1'b0;
    logic [NUM_CH-1:0] spi_cs_n;
    logic              spi_sclk;
    logic              sample_valid;
    logic [CH_W-1:0]   sample_ch;
    logic [11:0]       sample_raw;
    logic [9:0]        sample_celsius;
    logic              sample_open;
    logic              sample_fault;
    logic              busy;

    always #5 clk = ~clk;

    max6675_scan_ctrl #(
        .NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .CS_SETUP(CS_SETUP), .SAMPLE_PERIOD(P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_miso(spi_miso),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_raw(sample_raw),
        .sample_celsius(sample_celsius), .sample_open(sample_open),
        .sample_fault(sample_fault), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Directed vectors, three channels per scan, with hand-computed decodes.
    logic [15:0] vf   [12] = '{16'h0640, 16'h0C80, 16'h12C0,
                               16'h0004, 16'h7FF8, 16'h8000,
                               16'h0002, 16'h0C80, 16'h7FFF,
                               16'h0C80, 16'h0640, 16'h0000};
    logic [11:0] vraw [12] = '{12'h0C8, 12'h190, 12'h258,
                               12'h000, 12'hFFF, 12'h000,
                               12'h000, 12'h190, 12'hFFF,
                               12'h190, 12'h0C8, 12'h000};
    logic [9:0]  vcel [12] = '{10'd50, 10'd100, 10'd150,
                               10'd0, 10'd1023, 10'd0,
                               10'd0, 10'd100, 10'd1023,
                               10'd100, 10'd50, 10'd0};
    logic        vop  [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic        vflt [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] raw;
        logic [9:0]  cel;
        logic        op;
        logic        flt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] frame [NUM_CH];

    // MAX6675 model: MSB on SO at CS_n fall, next bit after each sclk fall.
    int   m_act = 0;
    int   m_bit = 0;
    logic m_prev_low = 1'b0;
    logic m_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (spi_cs_n != '1) begin
            if (!m_prev_low) begin
                for (int i = 0; i < NUM_CH; i++) if (!spi_cs_n[i]) m_act = i;
                m_bit    = 0;
                spi_miso = frame[m_act][15];
            end else if (m_prev_sclk && !spi_sclk) begin
                m_bit++;
                spi_miso = (m_bit < 16) ? frame[m_act][15 - m_bit] : 1'b0;
            end
        end else begin
            spi_miso = 1'b0;
        end
        m_prev_low  = (spi_cs_n != '1);
        m_prev_sclk = spi_sclk;
    end

    // Monitor: scoreboard pop on every strobe, plus bus timing checks.
    exp_t e;
    logic prev_rst = 1'b0;
    logic prev_sclk = 1'b0;
    int   since = 0;
    bit   in_win = 0;
    int   w_cyc = 0;
    int   rises = 0;
    int   last_rise = 0;
    int   gap = 0;
    bit   gap_valid = 0;
    int   falls = 0;
    int   starts[$];

    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_valid", sample_ch, 0);
            end else begin
                e = exp_q.pop_front();
                chk(sample_ch == e.ch, "sample_ch", sample_ch, e.ch);
                chk(sample_raw == e.raw, "sample_raw", sample_raw, e.raw);
                chk(sample_celsius == e.cel, "sample_celsius", sample_celsius, e.cel);
                chk(sample_open == e.op, "sample_open", sample_open, e.op);
                chk(sample_fault == e.flt, "sample_fault", sample_fault, e.flt);
            end
        end

        if (!prev_rst) begin
            since     = 0;
            in_win    = 0;
            gap_valid = 0;
            starts.delete();
        end else begin
            since++;
            if (spi_cs_n == '1) begin
                chk(!spi_sclk, "sclk_idle_low", spi_sclk, 0);
                if (in_win) begin
                    chk(rises == 16, "rises_per_cs", rises, 16);
                    in_win    = 0;
                    gap       = 1;
                    gap_valid = 1;
                end else begin
                    gap++;
                end
            end else begin
                chk($countones(~spi_cs_n) == 1, "cs_onehot", spi_cs_n, 0);
                if (!in_win) begin
                    in_win    = 1;
                    w_cyc     = 0;
                    rises     = 0;
                    falls++;
                    if (gap_valid && gap < 50) chk(gap >= SCLK_DIV, "cs_gap", gap, SCLK_DIV);
                    if (!spi_cs_n[0]) starts.push_back(since);
                end else begin
                    w_cyc++;
                    if (spi_sclk && !prev_sclk) begin
                        rises++;
                        if (rises == 1) chk(w_cyc == CS_SETUP, "first_rise", w_cyc, CS_SETUP);
                        else chk(w_cyc - last_rise == 2 * SCLK_DIV, "sclk_period",
                                 w_cyc - last_rise, 2 * SCLK_DIV);
                        last_rise = w_cyc;
                    end
                end
            end
        end
        prev_sclk = spi_sclk;
        prev_rst  = rst_n;
    end

    task automatic load_scan(input int s, input bit push);
        for (int c = 0; c < NUM_CH; c++) begin
            frame[c] = vf[3 * s + c];
            if (push) exp_q.push_back('{ch: 2'(c), raw: vraw[3 * s + c], cel: vcel[3 * s + c],
                                        op: vop[3 * s + c], flt: vflt[3 * s + c]});
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(busy === lvl, nm, busy, lvl);
    endtask

    task automatic run_scan();
        wait_busy(1'b1, 2 * P, "scan_start_timeout");
        wait_busy(1'b0, P, "scan_end_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int f0;
        int n;
        for (int c = 0; c < NUM_CH; c++) frame[c] = 16'h0000;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(spi_cs_n == '1, "reset_cs", spi_cs_n, 7);
        chk(spi_sclk == 1'b0, "reset_sclk", spi_sclk, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(sample_valid == 1'b0, "reset_valid", sample_valid, 0);
        chk({sample_ch, sample_raw, sample_celsius, sample_open, sample_fault} == '0,
            "reset_sample", sample_raw, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int s = 0; s < 3; s++) begin
            load_scan(s, 1'b1);
            run_scan();
        end
        chk(starts.size() == 3, "scan_count", starts.size(), 3);
        if (starts.size() == 3) begin
            chk(starts[0] == P, "first_tick", starts[0], P);
            chk(starts[1] - starts[0] == P, "scan_spacing1", starts[1] - starts[0], P);
            chk(starts[2] - starts[1] == P, "scan_spacing2", starts[2] - starts[1], P);
        end

        // Reset mid-transfer, during bit 7 of channel 0.
        load_scan(3, 1'b0);
        wait_busy(1'b1, 2 * P, "t6_start_timeout");
        n = 0;
        while (!(in_win && rises == 7) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk(rises == 7, "t6_bit7_reached", rises, 7);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(spi_cs_n == '1, "midreset_cs", spi_cs_n, 7);
        chk(spi_sclk == 1'b0, "midreset_sclk", spi_sclk, 0);
        chk(busy == 1'b0, "midreset_busy", busy, 0);
        chk(sample_valid == 1'b0, "midreset_valid", sample_valid, 0);
        chk(sample_raw == 12'h000, "midreset_raw", sample_raw, 0);
        chk(sample_fault == 1'b0, "midreset_fault", sample_fault, 0);

        @(posedge clk); #1;
        rst_n  = 1'b1;
        enable = 1'b0;
        f0 = falls;
        repeat (3 * P + 5) @(posedge clk);
        chk(falls == f0, "disabled_no_cs", falls - f0, 0);
        #1 enable = 1'b1;
        load_scan(3, 1'b1);
        run_scan();
        chk(starts.size() == 1, "reenable_scan_count", starts.size(), 1);
        if (starts.size() == 1) chk(starts[0] == 4 * P, "reenable_tick", starts[0], 4 * P);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
